// File: rtl/tx_packet_arbiter_if.sv
// Bus bundle between the response-source FIFOs, the packet arbiter and the UART tx byte port.
// The master side is the arbiter; the slave side is the sources plus the UART.
interface tx_packet_arbiter_if #(
    parameter int N_SRC = 8
);
    logic [N_SRC-1:0]   have_msg_bus;
    logic [8*N_SRC-1:0] src_len_bus;
    logic [8*N_SRC-1:0] src_data_bus;
    logic [N_SRC-1:0]   src_rd_bus;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic               busy;
    logic [7:0]         grant;

    modport master (
        input  have_msg_bus, src_len_bus, src_data_bus, tx_ready,
        output src_rd_bus, tx_data, tx_valid, busy, grant
    );

    modport slave (
        output have_msg_bus, src_len_bus, src_data_bus, tx_ready,
        input  src_rd_bus, tx_data, tx_valid, busy, grant
    );
endinterface

// File: rtl/tx_packet_arbiter.sv
// Round-robin arbiter that frames one source's message at a time into a host packet
// (prefix, src, dst, len, payload, checksum) and streams it byte-by-byte to the UART.
//
// state | meaning
// IDLE  | waiting for any have_msg bit; picks the next requester round-robin
// LOAD  | registers the byte selected by field; pops the source for payload bytes
// SEND  | holds tx_data with tx_valid high until the UART accepts it
module tx_packet_arbiter #(
    parameter int         N_SRC     = 8,
    parameter logic [7:0] PREFIX    = 8'hDD,
    parameter logic [7:0] HOST_ADDR = 8'h01
) (
    input logic                 clk,
    input logic                 n_rst,
    tx_packet_arbiter_if.master bus
);
    localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} state_t;
    typedef enum logic [2:0] {F_PFX, F_SRC, F_DST, F_LEN, F_PAY, F_CRC} field_t;

    state_t           state_q;
    field_t           field_q;
    logic [7:0]       grant_q;
    logic [7:0]       rr_ptr_q;
    logic [7:0]       len_q;
    logic [7:0]       crc_q;
    logic [7:0]       cnt_q;
    logic [7:0]       tx_data_q;
    logic             tx_valid_q;
    logic [N_SRC-1:0] src_rd_q;

    logic [7:0]       len_arr  [N_SRC];
    logic [7:0]       data_arr [N_SRC];
    logic [N_SRC-1:0] req_rot;
    logic             rr_hit;
    logic [8:0]       rr_sum;
    logic [7:0]       rr_pick;
    logic [IW-1:0]    pick_idx;
    logic [IW-1:0]    gidx;
    logic [7:0]       head;

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            len_arr[i]  = bus.src_len_bus[8*i +: 8];
            data_arr[i] = bus.src_data_bus[8*i +: 8];
        end
    end

    // Rotate requests so bit 0 is rr_ptr; the lowest set bit is the next grant.
    always_comb begin
        req_rot = N_SRC'({bus.have_msg_bus, bus.have_msg_bus} >> rr_ptr_q);
        rr_hit  = 1'b0;
        rr_sum  = {1'b0, rr_ptr_q};
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                rr_hit = 1'b1;
                rr_sum = {1'b0, rr_ptr_q} + 9'(i);
            end
        end
        if (rr_sum >= 9'(N_SRC)) begin
            rr_sum = rr_sum - 9'(N_SRC);
        end
        rr_pick = 8'(rr_sum);
    end

    assign pick_idx = rr_pick[IW-1:0];
    assign gidx     = grant_q[IW-1:0];
    assign head     = data_arr[gidx];

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q    <= S_IDLE;
            field_q    <= F_PFX;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            len_q      <= '0;
            crc_q      <= '0;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            src_rd_q   <= '0;
        end else begin
            src_rd_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (rr_hit) begin
                        grant_q <= rr_pick;
                        len_q   <= len_arr[pick_idx];
                        crc_q   <= '0;
                        cnt_q   <= '0;
                        field_q <= F_PFX;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    case (field_q)
                        F_SRC: tx_data_q <= grant_q;
                        F_DST: tx_data_q <= HOST_ADDR;
                        F_LEN: tx_data_q <= len_q;
                        F_PAY: begin
                            tx_data_q      <= head;
                            src_rd_q[gidx] <= 1'b1;
                            crc_q          <= crc_q + head;
                            cnt_q          <= cnt_q + 8'd1;
                        end
                        F_CRC:   tx_data_q <= crc_q;
                        default: tx_data_q <= PREFIX;
                    endcase
                    tx_valid_q <= 1'b1;
                    state_q    <= S_SEND;
                end
                S_SEND: begin
                    if (bus.tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= S_LOAD;
                        case (field_q)
                            F_PFX: field_q <= F_SRC;
                            F_SRC: field_q <= F_DST;
                            F_DST: field_q <= F_LEN;
                            F_LEN: field_q <= (len_q != 8'd0) ? F_PAY : F_CRC;
                            F_PAY: field_q <= (cnt_q < len_q) ? F_PAY : F_CRC;
                            default: begin
                                state_q  <= S_IDLE;
                                rr_ptr_q <= (grant_q == 8'(N_SRC - 1)) ? 8'd0 : grant_q + 8'd1;
                            end
                        endcase
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.tx_data    = tx_data_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.src_rd_bus = src_rd_q;
    assign bus.grant      = grant_q;
    assign bus.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_tx_packet_arbiter.sv
// Bench for tx_packet_arbiter: modelled source FIFOs, a UART sink with random backpressure,
// and a packet-level round-robin model that predicts every byte on the wire.
module tb_tx_packet_arbiter;
    localparam int         N    = 8;
    localparam logic [7:0] PFX  = 8'hDD;
    localparam logic [7:0] HOST = 8'h01;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;

    tx_packet_arbiter_if #(.N_SRC(N)) bus ();

    tx_packet_arbiter #(.N_SRC(N), .PREFIX(PFX), .HOST_ADDR(HOST)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] src_lens  [N][$];
    logic [7:0] src_bytes [N][$];
    logic [7:0] exp_bytes [$];
    int         exp_pkt_src [$];
    int         exp_pkt_len [$];
    int         m_ptr      = 0;
    int         rx_in_pkt  = 0;
    int         pops_seen  = 0;
    int         exp_pops   = 0;
    int         stall_left = 0;
    bit         rand_ready = 1'b0;
    bit         long_stall_req = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_src();
        for (int i = 0; i < N; i++) begin
            bus.have_msg_bus[i]       = (src_lens[i].size() != 0);
            bus.src_len_bus[8*i +: 8]  = (src_lens[i].size() != 0) ? src_lens[i][0] : 8'h00;
            bus.src_data_bus[8*i +: 8] = (src_bytes[i].size() != 0) ? src_bytes[i][0] : 8'h00;
        end
    endtask

    task automatic add_msg(input int s, input int len, input int base);
        src_lens[s].push_back(8'(len));
        for (int j = 0; j < len; j++) begin
            if (base < 0) src_bytes[s].push_back(8'($urandom_range(0, 255)));
            else          src_bytes[s].push_back(8'(base + j));
        end
    endtask

    // Packet-level model: serve pending messages round-robin from m_ptr.
    task automatic build_expected();
        logic [7:0] ml [N][$];
        logic [7:0] mb [N][$];
        int         g;
        logic [7:0] len;
        logic [7:0] sum;
        logic [7:0] b;
        for (int i = 0; i < N; i++) begin
            ml[i] = src_lens[i];
            mb[i] = src_bytes[i];
        end
        pops_seen = 0;
        exp_pops  = 0;
        for (int p = 0; p < 1000; p++) begin
            g = -1;
            for (int k = N - 1; k >= 0; k--) begin
                if (ml[(m_ptr + k) % N].size() != 0) g = (m_ptr + k) % N;
            end
            if (g < 0) break;
            len = ml[g].pop_front();
            sum = 8'h00;
            exp_bytes.push_back(PFX);
            exp_bytes.push_back(8'(g));
            exp_bytes.push_back(HOST);
            exp_bytes.push_back(len);
            for (int j = 0; j < int'(len); j++) begin
                b = mb[g].pop_front();
                exp_bytes.push_back(b);
                sum = sum + b;
            end
            exp_bytes.push_back(sum);
            exp_pkt_src.push_back(g);
            exp_pkt_len.push_back(int'(len) + 5);
            exp_pops += int'(len);
            m_ptr = (g + 1) % N;
        end
        drive_src();
    endtask

    task automatic step();
        logic [7:0] b;
        int         s;
        @(negedge clk);
        if (prev_stall) begin
            chk("stall_valid", bus.tx_valid, 1);
            chk("stall_data", bus.tx_data, prev_data);
        end
        if (stall_left > 0) begin
            bus.tx_ready = 1'b0;
            stall_left--;
        end else if (long_stall_req && bus.tx_valid && $urandom_range(0, 5) == 0) begin
            bus.tx_ready   = 1'b0;
            stall_left     = 49;
            long_stall_req = 1'b0;
        end else begin
            bus.tx_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        prev_stall = bus.tx_valid && !bus.tx_ready;
        prev_data  = bus.tx_data;
        if (bus.src_rd_bus != '0) begin
            pops_seen++;
            if (exp_pkt_src.size() != 0) chk("pop_target", bus.src_rd_bus, 32'(1) << exp_pkt_src[0]);
            else                         chk("pop_unexpected", bus.src_rd_bus, 0);
            for (int i = 0; i < N; i++) begin
                if (bus.src_rd_bus[i] && src_bytes[i].size() != 0) void'(src_bytes[i].pop_front());
            end
        end
        if (bus.tx_valid && bus.tx_ready) begin
            b = 8'hxx;
            if (exp_bytes.size() != 0) b = exp_bytes.pop_front();
            chk("tx_byte", bus.tx_data, b);
            if (exp_pkt_len.size() != 0) begin
                rx_in_pkt++;
                if (rx_in_pkt == exp_pkt_len[0]) begin
                    s = exp_pkt_src.pop_front();
                    void'(exp_pkt_len.pop_front());
                    rx_in_pkt = 0;
                    if (src_lens[s].size() != 0) void'(src_lens[s].pop_front());
                end
            end
        end
        drive_src();
    endtask

    task automatic run_scn(input int budget);
        int n = 0;
        while ((exp_bytes.size() != 0 || bus.busy !== 1'b0) && n < budget) begin
            step();
            n++;
        end
        chk("finish_in_budget", 32'(n < budget), 1);
        chk("idle_busy", bus.busy, 0);
        chk("idle_valid", bus.tx_valid, 0);
        chk("pops_total", pops_seen, exp_pops);
    endtask

    initial begin
        int n;
        bus.tx_ready = 1'b1;
        drive_src();
        repeat (3) step();
        chk("rst_tx_valid", bus.tx_valid, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        chk("rst_src_rd", bus.src_rd_bus, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_grant", bus.grant, 0);
        n_rst = 1'b1;
        step();

        // Single packet from source 3, with first-byte latency checks.
        add_msg(3, 6, 1);
        build_expected();
        step();
        chk("lat_busy", bus.busy, 1);
        chk("lat_grant", bus.grant, 3);
        chk("lat_valid_low", bus.tx_valid, 0);
        step();
        chk("lat_valid_high", bus.tx_valid, 1);
        chk("lat_prefix", bus.tx_data, PFX);
        run_scn(200);

        // Checksum wrap from source 0.
        src_lens[0].push_back(8'd2);
        src_bytes[0].push_back(8'hFF);
        src_bytes[0].push_back(8'h02);
        build_expected();
        run_scn(200);

        // Zero-length message from source 5.
        add_msg(5, 0, 0);
        build_expected();
        run_scn(200);

        // Sources 1 and 2 both pending, then source 2 alone.
        add_msg(1, 3, -1);
        add_msg(2, 4, -1);
        add_msg(1, 2, -1);
        add_msg(2, 1, -1);
        build_expected();
        run_scn(400);
        add_msg(2, 2, -1);
        add_msg(2, 0, 0);
        add_msg(2, 3, -1);
        build_expected();
        run_scn(400);

        // Random traffic with random and long backpressure.
        for (int r = 0; r < 6; r++) begin
            rand_ready     = (r >= 2);
            long_stall_req = (r == 3 || r == 5);
            n = 0;
            for (int s = 0; s < N; s++) begin
                if ($urandom_range(0, 1) == 1) begin
                    add_msg(s, $urandom_range(0, 9), -1);
                    n++;
                    if ($urandom_range(0, 1) == 1) add_msg(s, $urandom_range(0, 9), -1);
                end
            end
            if (n == 0) add_msg($urandom_range(0, N - 1), $urandom_range(0, 9), -1);
            build_expected();
            run_scn(4000);
        end
        rand_ready     = 1'b0;
        long_stall_req = 1'b0;
        stall_left     = 0;

        // Leave the pointer at 6, then reset in the middle of a source-4 packet.
        add_msg(5, 3, -1);
        build_expected();
        run_scn(200);
        add_msg(4, 8, -1);
        build_expected();
        n = 0;
        while (pops_seen < 4 && n < 200) begin
            step();
            n++;
        end
        chk("mid_pops_reached", pops_seen, 4);
        n_rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            src_lens[i].delete();
            src_bytes[i].delete();
        end
        exp_bytes.delete();
        exp_pkt_src.delete();
        exp_pkt_len.delete();
        rx_in_pkt  = 0;
        m_ptr      = 0;
        prev_stall = 1'b0;
        drive_src();
        step();
        chk("mid_rst_valid", bus.tx_valid, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_src_rd", bus.src_rd_bus, 0);
        chk("mid_rst_grant", bus.grant, 0);
        n_rst = 1'b1;
        prev_stall = 1'b0;
        step();
        add_msg(6, 5, -1);
        add_msg(2, 3, -1);
        build_expected();
        run_scn(400);

        repeat (5) step();
        chk("final_busy", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
